// File: rtl/ramp_seq_pkg.sv
// Shared state encoding and direction constants for the ramp sequencer.
package ramp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DWELL = 3'd2,
    DOWN  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ramp_counter_core.sv
// Up/down counter datapath with synchronous load and enable; load has priority.
module ramp_counter_core
  import ramp_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= (i_up == DIR_UP) ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ramp_sequencer.sv
// Trapezoidal ramp controller: floor -> peak, dwell, peak -> floor, repeated reps times.
// Optional pause input enabled by defining RAMP_SEQ_PAUSE_EN.
module ramp_sequencer
  import ramp_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REPS_W  = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
`ifdef RAMP_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [WIDTH-1:0]   floor_val,
  input  logic [WIDTH-1:0]   peak_val,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [REPS_W-1:0]  reps,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [REPS_W-1:0]  rep_cnt
);

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_floor, r_peak, w_count;
  logic [DWELL_W-1:0] r_dwell, r_dwell_cnt;
  logic [REPS_W-1:0]  r_reps, r_rep_cnt;
  logic               r_dir, r_err, w_err_next;
  logic               w_latch, w_load, w_en, w_up, w_adv, w_rep_inc;
  logic               w_at_peak, w_at_floor, w_last_rep;

`ifdef RAMP_SEQ_PAUSE_EN
  assign w_adv = ~pause;
`else
  assign w_adv = 1'b1;
`endif

  // Bounds are checked against the value the counter is about to take.
  assign w_at_peak  = (w_count + WIDTH'(1)) == r_peak;
  assign w_at_floor = (w_count - WIDTH'(1)) == r_floor;
  assign w_last_rep = (r_rep_cnt + REPS_W'(1)) == r_reps;

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_up         = DIR_UP;
    w_rep_inc    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (floor_val >= peak_val) begin
            w_state_next = DONE;
            w_err_next   = 1'b1;
          end else if (reps == '0) begin
            w_state_next = DONE;
            w_err_next   = 1'b0;
          end else begin
            w_state_next = UP;
            w_err_next   = 1'b0;
            w_latch      = 1'b1;
            w_load       = 1'b1;
          end
        end
      end
      UP: begin
        if (w_adv) begin
          w_en = 1'b1;
          if (w_at_peak) w_state_next = (r_dwell != '0) ? DWELL : DOWN;
        end
      end
      DWELL: begin
        if (w_adv && (r_dwell_cnt == r_dwell - DWELL_W'(1))) w_state_next = DOWN;
      end
      DOWN: begin
        if (w_adv) begin
          w_en = 1'b1;
          w_up = DIR_DOWN;
          if (w_at_floor) begin
            w_rep_inc    = 1'b1;
            w_state_next = w_last_rep ? DONE : UP;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle completion.
    if (abort && (r_state != IDLE)) begin
      w_state_next = IDLE;
      w_en         = 1'b0;
      w_rep_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_floor     <= '0;
      r_peak      <= '0;
      r_dwell     <= '0;
      r_reps      <= '0;
      r_dwell_cnt <= '0;
      r_rep_cnt   <= '0;
      r_dir       <= DIR_UP;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_latch) begin
        r_floor <= floor_val;
        r_peak  <= peak_val;
        r_dwell <= dwell_cycles;
        r_reps  <= reps;
      end
      if (w_latch) begin
        r_rep_cnt <= '0;
      end else if (w_rep_inc) begin
        r_rep_cnt <= r_rep_cnt + REPS_W'(1);
      end
      // Falling steps clear dir; landing on floor for another rep sets it again.
      if (w_latch) begin
        r_dir <= DIR_UP;
      end else if (w_en && (w_up == DIR_DOWN)) begin
        r_dir <= (w_state_next == UP) ? DIR_UP : DIR_DOWN;
      end
      if ((r_state == DWELL) && (w_state_next == DWELL)) begin
        if (w_adv) r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end else begin
        r_dwell_cnt <= '0;
      end
    end
  end

  ramp_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (floor_val),
    .i_en       (w_en),
    .i_up       (w_up),
    .o_count    (w_count)
  );

  assign count   = w_count;
  assign dir     = r_dir;
  assign busy    = (r_state == UP) || (r_state == DWELL) || (r_state == DOWN);
  assign done    = (r_state == DONE);
  assign err     = r_err && (r_state == DONE);
  assign rep_cnt = r_rep_cnt;

endmodule
